light_scheduler: RTL and testbench

LIGHT_SCHEDULER -- requirements
Module: light_scheduler

---
 rtl/light_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_light_scheduler.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/light_scheduler.sv
// ---------------------------------------------------------------------------
// light_scheduler
//
// Occupancy/ambient driven lamp controller. Night-time motion fades the lamp
// up to full brightness, keeps it there while motion continues, drops to a
// power-saving DIM level after a hold period and finally fades out. Manual
// force-on / force-off requests override the automatic behaviour, with
// force-off taking precedence.
//
// Parameters:
//   HOLD_CYCLES - full-brightness cycles kept after the last motion
//   DIM_CYCLES  - cycles spent in DIM before fading out
//   DIM_LEVEL   - 8-bit brightness used while in DIM
//   RAMP_STEP   - brightness change per cycle while fading
//
// Ports:
//   clk         - single clock, all state updates on its rising edge
//   reset       - asynchronous, active-high reset
//   motion      - occupancy sensor, 1 = motion
//   light_level - ambient sensor, 1 = night, 0 = day
//   manual_on   - manual force-on request (level)
//   manual_off  - manual force-off request (level, highest priority)
//   brightness  - registered lamp brightness, 0 = off, 255 = full
//   pwm_out     - registered PWM drive, high while pwm counter < brightness
//   light       - registered, 1 when brightness != 0
//   state       - current FSM state encoding
//
// Configuration macro:
//   LIGHT_FADE_EN - when defined, RAMP_UP/RAMP_DOWN step the brightness by
//                   RAMP_STEP per cycle; when undefined each ramp state jumps
//                   straight to 255 / 0 and lasts exactly one cycle.
// ---------------------------------------------------------------------------
module light_scheduler #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned DIM_CYCLES  = 32,
    parameter logic [7:0]  DIM_LEVEL   = 8'd64,
    parameter logic [7:0]  RAMP_STEP   = 8'd16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       motion,
    input  logic       light_level,
    input  logic       manual_on,
    input  logic       manual_off,
    output logic [7:0] brightness,
    output logic       pwm_out,
    output logic       light,
    output logic [2:0] state
);

`ifdef LIGHT_FADE_EN
    localparam logic FADE_EN = 1'b1;
`else
    localparam logic FADE_EN = 1'b0;
`endif

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES);
    localparam logic [15:0] DIM_LOAD  = 16'(DIM_CYCLES);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_ON        = 3'd2,
        ST_DIM       = 3'd3,
        ST_RAMP_DOWN = 3'd4,
        ST_MANUAL    = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [7:0]  brightness_r;
    logic [7:0]  bright_nx_s;
    logic [15:0] hold_cnt_r;
    logic [15:0] hold_nx_s;
    logic [15:0] dim_cnt_r;
    logic [15:0] dim_nx_s;
    logic [7:0]  pwm_cnt_r;
    logic [7:0]  pwm_cnt_nx_s;
    logic        pwm_r;
    logic        light_r;
    logic [7:0]  up_val_s;
    logic [7:0]  down_val_s;

    // Saturating add through a 9-bit intermediate so 255 never wraps to a small value.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > 9'd255) begin
            sat_add = 8'd255;
        end else begin
            sat_add = sum[7:0];
        end
    endfunction

    // Saturating subtract through a 9-bit intermediate; a borrow means clamp to 0.
    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[8]) begin
            sat_sub = 8'd0;
        end else begin
            sat_sub = diff[7:0];
        end
    endfunction

    // Brightness targets for the two ramp states (stepped or instantaneous).
    assign up_val_s     = FADE_EN ? sat_add(brightness_r, RAMP_STEP) : 8'd255;
    assign down_val_s   = FADE_EN ? sat_sub(brightness_r, RAMP_STEP) : 8'd0;
    assign pwm_cnt_nx_s = pwm_cnt_r + 8'd1;

    // Next-state, next-brightness and counter logic with manual overrides first.
    always_comb begin
        state_nx_s  = state_r;
        bright_nx_s = brightness_r;
        hold_nx_s   = hold_cnt_r;
        dim_nx_s    = dim_cnt_r;
        if (manual_off) begin
            state_nx_s  = ST_OFF;
            bright_nx_s = 8'd0;
            hold_nx_s   = 16'd0;
            dim_nx_s    = 16'd0;
        end else if (manual_on) begin
            state_nx_s  = ST_MANUAL;
            bright_nx_s = 8'd255;
            hold_nx_s   = 16'd0;
            dim_nx_s    = 16'd0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    bright_nx_s = 8'd0;
                    if (motion && light_level) begin
                        state_nx_s = ST_RAMP_UP;
                    end else begin
                        state_nx_s = ST_OFF;
                    end
                end
                ST_RAMP_UP: begin
                    bright_nx_s = up_val_s;
                    if (up_val_s == 8'd255) begin
                        state_nx_s = ST_ON;
                        hold_nx_s  = HOLD_LOAD;
                    end else begin
                        state_nx_s = ST_RAMP_UP;
                    end
                end
                ST_ON: begin
                    // Daylight wins over both motion and the hold timer.
                    if (!light_level) begin
                        state_nx_s = ST_RAMP_DOWN;
                        hold_nx_s  = 16'd0;
                    end else if (motion) begin
                        hold_nx_s = HOLD_LOAD;
                    end else if (hold_cnt_r <= 16'd1) begin
                        state_nx_s  = ST_DIM;
                        bright_nx_s = DIM_LEVEL;
                        hold_nx_s   = 16'd0;
                        dim_nx_s    = DIM_LOAD;
                    end else begin
                        hold_nx_s = hold_cnt_r - 16'd1;
                    end
                end
                ST_DIM: begin
                    if (!light_level) begin
                        state_nx_s = ST_RAMP_DOWN;
                        dim_nx_s   = 16'd0;
                    end else if (motion) begin
                        state_nx_s = ST_RAMP_UP;
                        dim_nx_s   = 16'd0;
                    end else if (dim_cnt_r <= 16'd1) begin
                        state_nx_s = ST_RAMP_DOWN;
                        dim_nx_s   = 16'd0;
                    end else begin
                        dim_nx_s = dim_cnt_r - 16'd1;
                    end
                end
                ST_RAMP_DOWN: begin
                    // Re-trigger keeps the current brightness and climbs from there.
                    if (motion && light_level) begin
                        state_nx_s = ST_RAMP_UP;
                    end else if (down_val_s == 8'd0) begin
                        state_nx_s  = ST_OFF;
                        bright_nx_s = 8'd0;
                    end else begin
                        bright_nx_s = down_val_s;
                    end
                end
                ST_MANUAL: begin
                    bright_nx_s = 8'd255;
                end
                default: begin
                    state_nx_s  = ST_OFF;
                    bright_nx_s = 8'd0;
                    hold_nx_s   = 16'd0;
                    dim_nx_s    = 16'd0;
                end
            endcase
        end
    end

    // State, counters and all outputs registered together; pwm/light use next brightness.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_OFF;
            brightness_r <= 8'd0;
            hold_cnt_r   <= 16'd0;
            dim_cnt_r    <= 16'd0;
            pwm_cnt_r    <= 8'd0;
            pwm_r        <= 1'b0;
            light_r      <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            brightness_r <= bright_nx_s;
            hold_cnt_r   <= hold_nx_s;
            dim_cnt_r    <= dim_nx_s;
            pwm_cnt_r    <= pwm_cnt_nx_s;
            pwm_r        <= (pwm_cnt_nx_s < bright_nx_s);
            light_r      <= (bright_nx_s != 8'd0);
        end
    end

    assign brightness = brightness_r;
    assign pwm_out    = pwm_r;
    assign light      = light_r;
    assign state      = state_r;

endmodule

// File: tb/tb_light_scheduler.sv
// ---------------------------------------------------------------------------
// tb_light_scheduler
//
// Self-checking bench for light_scheduler. A behavioural reference model is
// advanced once per clock from the inputs about to be sampled; its expected
// outputs are pushed to a scoreboard queue and popped after the edge for
// comparison. Scenario tasks add direct checks of the timing landmarks.
// Works with or without LIGHT_FADE_EN defined.
// ---------------------------------------------------------------------------
module tb_light_scheduler;

    localparam int HOLD = 16;
    localparam int DIMC = 32;
    localparam int DIML = 64;
    localparam int STEP = 16;
`ifdef LIGHT_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       motion;
    logic       light_level;
    logic       manual_on;
    logic       manual_off;
    logic [7:0] brightness;
    logic       pwm_out;
    logic       light;
    logic [2:0] state;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] br;
        logic       lt;
        logic       pw;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model state
    int m_st, m_br, m_hold, m_dim, m_pwm;

    light_scheduler #(
        .HOLD_CYCLES(HOLD),
        .DIM_CYCLES (DIMC),
        .DIM_LEVEL  (8'(DIML)),
        .RAMP_STEP  (8'(STEP))
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .motion     (motion),
        .light_level(light_level),
        .manual_on  (manual_on),
        .manual_off (manual_off),
        .brightness (brightness),
        .pwm_out    (pwm_out),
        .light      (light),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        m_st = 0; m_br = 0; m_hold = 0; m_dim = 0; m_pwm = 0;
    endtask

    // Reference behaviour for one rising edge, from the requirements.
    task automatic model_clock();
        int b;
        m_pwm = (m_pwm + 1) % 256;
        if (manual_off) begin
            m_st = 0; m_br = 0; m_hold = 0; m_dim = 0;
        end else if (manual_on) begin
            m_st = 5; m_br = 255; m_hold = 0; m_dim = 0;
        end else begin
            case (m_st)
                0: if (motion && light_level) m_st = 1;
                1: begin
                    b = FADE ? m_br + STEP : 255;
                    if (b >= 255) begin
                        m_br = 255; m_st = 2; m_hold = HOLD;
                    end else begin
                        m_br = b;
                    end
                end
                2: begin
                    if (!light_level) begin
                        m_st = 4; m_hold = 0;
                    end else if (motion) begin
                        m_hold = HOLD;
                    end else begin
                        m_hold = m_hold - 1;
                        if (m_hold <= 0) begin
                            m_hold = 0; m_st = 3; m_br = DIML; m_dim = DIMC;
                        end
                    end
                end
                3: begin
                    if (!light_level) begin
                        m_st = 4; m_dim = 0;
                    end else if (motion) begin
                        m_st = 1; m_dim = 0;
                    end else begin
                        m_dim = m_dim - 1;
                        if (m_dim <= 0) begin
                            m_dim = 0; m_st = 4;
                        end
                    end
                end
                4: begin
                    if (motion && light_level) begin
                        m_st = 1;
                    end else begin
                        b = FADE ? m_br - STEP : 0;
                        if (b <= 0) begin
                            m_br = 0; m_st = 0;
                        end else begin
                            m_br = b;
                        end
                    end
                end
                default: m_br = 255;
            endcase
        end
    endtask

    // One clock: push model expectation, clock the DUT, pop and compare.
    task automatic step();
        exp_t e;
        model_clock();
        e.st = 3'(m_st);
        e.br = 8'(m_br);
        e.lt = (m_br != 0);
        e.pw = (m_pwm < m_br);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n_checks++;
        if (state !== e.st) begin
            n_fail++;
            $display("FAIL sb_state t=%0t got %0d expected %0d", $time, state, e.st);
        end
        n_checks++;
        if (brightness !== e.br) begin
            n_fail++;
            $display("FAIL sb_brightness t=%0t got %0d expected %0d", $time, brightness, e.br);
        end
        n_checks++;
        if (light !== e.lt) begin
            n_fail++;
            $display("FAIL sb_light t=%0t got %0b expected %0b", $time, light, e.lt);
        end
        n_checks++;
        if (pwm_out !== e.pw) begin
            n_fail++;
            $display("FAIL sb_pwm t=%0t got %0b expected %0b", $time, pwm_out, e.pw);
        end
    endtask

    task automatic set_in(input logic mo, input logic ll, input logic mon, input logic moff);
        motion = mo; light_level = ll; manual_on = mon; manual_off = moff;
    endtask

    task automatic test_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        n_checks++;
        if (state !== 3'd0 || brightness !== 8'd0 || pwm_out !== 1'b0 || light !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async got st=%0d br=%0d pwm=%0b lt=%0b expected 0 0 0 0",
                     state, brightness, pwm_out, light);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (state !== 3'd0 || brightness !== 8'd0 || pwm_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held got st=%0d br=%0d pwm=%0b expected 0 0 0", state, brightness, pwm_out);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_day_motion();
        int lit = 0;
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            step();
            if (light !== 1'b0 || state !== 3'd0) lit++;
        end
        n_checks++;
        if (lit != 0) begin
            n_fail++;
            $display("FAIL day_motion got %0d lit/non-off cycles expected 0", lit);
        end
    endtask

    task automatic test_fade_on();
        int edges = 0;
        int ramp = 0;
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && state != 3'd2; i++) begin
            step();
            edges++;
            if (state == 3'd1) ramp++;
        end
        n_checks++;
        if (state !== 3'd2 || brightness !== 8'd255) begin
            n_fail++;
            $display("FAIL fade_on_final got st=%0d br=%0d expected 2 255", state, brightness);
        end
        n_checks++;
        if (edges != (FADE ? 17 : 2)) begin
            n_fail++;
            $display("FAIL fade_on_latency got %0d edges expected %0d", edges, FADE ? 17 : 2);
        end
        n_checks++;
        if (ramp != (FADE ? 16 : 1)) begin
            n_fail++;
            $display("FAIL fade_on_ramp_cycles got %0d expected %0d", ramp, FADE ? 16 : 1);
        end
    endtask

    task automatic test_hold_dim();
        int edges = 0;
        int down = 0;
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && state != 3'd3; i++) begin
            step();
            edges++;
        end
        n_checks++;
        if (edges != HOLD || state !== 3'd3 || brightness !== 8'(DIML)) begin
            n_fail++;
            $display("FAIL hold_to_dim got edges=%0d st=%0d br=%0d expected %0d 3 %0d",
                     edges, state, brightness, HOLD, DIML);
        end
        edges = 0;
        for (int i = 0; i < 60 && state != 3'd4; i++) begin
            step();
            edges++;
        end
        n_checks++;
        if (edges != DIMC || state !== 3'd4) begin
            n_fail++;
            $display("FAIL dim_expiry got edges=%0d st=%0d expected %0d 4", edges, state, DIMC);
        end
        down = 1;
        for (int i = 0; i < 40 && state != 3'd0; i++) begin
            step();
            if (state == 3'd4) down++;
        end
        n_checks++;
        if (down != (FADE ? 4 : 1) || state !== 3'd0 || brightness !== 8'd0) begin
            n_fail++;
            $display("FAIL ramp_down got cycles=%0d st=%0d br=%0d expected %0d 0 0",
                     down, state, brightness, FADE ? 4 : 1);
        end
    endtask

    task automatic test_retrigger();
        int ramp = 0;
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && state != 3'd2; i++) step();
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && state != 3'd3; i++) step();
        step();
        step();
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        n_checks++;
        if (state !== 3'd1 || brightness !== 8'(DIML)) begin
            n_fail++;
            $display("FAIL retrigger_entry got st=%0d br=%0d expected 1 %0d", state, brightness, DIML);
        end
        ramp = 1;
        for (int i = 0; i < 40 && state != 3'd2; i++) begin
            step();
            if (state == 3'd1) ramp++;
        end
        n_checks++;
        if (ramp != (FADE ? 12 : 1) || brightness !== 8'd255) begin
            n_fail++;
            $display("FAIL retrigger_ramp got cycles=%0d br=%0d expected %0d 255",
                     ramp, brightness, FADE ? 12 : 1);
        end
    endtask

    task automatic test_manual();
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        step();
        n_checks++;
        if (state !== 3'd0 || brightness !== 8'd0) begin
            n_fail++;
            $display("FAIL manual_both got st=%0d br=%0d expected 0 0", state, brightness);
        end
        set_in(1'b0, 1'b1, 1'b1, 1'b0);
        step();
        n_checks++;
        if (state !== 3'd5 || brightness !== 8'd255) begin
            n_fail++;
            $display("FAIL manual_on got st=%0d br=%0d expected 5 255", state, brightness);
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step();
        n_checks++;
        if (state !== 3'd5 || brightness !== 8'd255) begin
            n_fail++;
            $display("FAIL manual_hold_day got st=%0d br=%0d expected 5 255", state, brightness);
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_ramp_down_reenter();
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && state != 3'd2; i++) step();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        n_checks++;
        if (state !== 3'd1 || brightness !== 8'd255) begin
            n_fail++;
            $display("FAIL ramp_down_reenter got st=%0d br=%0d expected 1 255", state, brightness);
        end
        for (int i = 0; i < 40 && state != 3'd2; i++) step();
    endtask

    task automatic test_reset_mid_ramp();
        set_in(1'b0, 1'b1, 1'b0, 1'b1);
        step();
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        n_checks++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL mid_ramp_pre got st=%0d expected 1", state);
        end
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if (state !== 3'd0 || brightness !== 8'd0 || pwm_out !== 1'b0 || light !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_ramp_reset got st=%0d br=%0d pwm=%0b lt=%0b expected 0 0 0 0",
                     state, brightness, pwm_out, light);
        end
        #1 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            manual_off  = ($urandom_range(0, 29) == 0);
            manual_on   = ($urandom_range(0, 24) == 0);
            motion      = ($urandom_range(0, 3) == 0);
            light_level = ($urandom_range(0, 7) != 0);
            step();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_day_motion();
        test_fade_on();
        test_hold_dim();
        test_retrigger();
        test_manual();
        test_ramp_down_reenter();
        test_reset_mid_ramp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
